// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, imem req/ack, IF/ID producer (optional IFU_PERF_CNT_EN wait counter)
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_wait_cnt_o
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] KILL  = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] hold_inst_q;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;

    // Masking (rather than slicing) keeps every redirect bit in use; low bits are forced to word alignment.
    assign redirect_target = redirect_pc_i & ~32'd3;
    assign pc_inc          = pc_q + 32'(PC_STEP);

    // State, PC and hold register update; redirect outranks ack and stall in every state.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            hold_inst_q <= 32'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    req_addr_q <= pc_q;
                    if (redirect_i) begin
                        pc_q    <= redirect_target;
                        state_q <= imem_ack_i ? FETCH : KILL;
                    end else if (imem_ack_i) begin
                        if (stall_i) begin
                            hold_inst_q <= imem_rdata_i;
                            state_q     <= HOLD;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= redirect_target;
                        state_q <= FETCH;
                    end else if (!stall_i) begin
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end
                end
                KILL: begin
                    // The old request must still complete; pc_q already holds the target.
                    if (redirect_i) begin
                        pc_q <= redirect_target;
                    end
                    if (imem_ack_i) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Output decode; reset forces a quiet bus and a bubble at RESET_PC.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        valid_o     = 1'b0;
        inst_o      = 32'd0;
        pc_o        = pc_q;
        if (!rst_n_i) begin
            imem_addr_o = RESET_PC;
            pc_o        = RESET_PC;
        end else begin
            case (state_q)
                FETCH: begin
                    imem_req_o = 1'b1;
                    valid_o    = imem_ack_i && !redirect_i;
                    inst_o     = valid_o ? imem_rdata_i : 32'd0;
                end
                HOLD: begin
                    valid_o = !redirect_i;
                    inst_o  = valid_o ? hold_inst_q : 32'd0;
                end
                KILL: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = req_addr_q;
                end
                default: begin
                    imem_req_o = 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] wait_cnt_q;

    // Count cycles the memory leaves a request unanswered; saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wait_cnt_q <= 32'd0;
        end else if (imem_req_o && !imem_ack_i && (wait_cnt_q != 32'hFFFF_FFFF)) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign fetch_wait_cnt_o = wait_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] wait_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 0;
    int wcnt   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .inst_o        (inst),
        .pc_o          (pc),
        .valid_o       (valid)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_wait_cnt_o (wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after lat waiting cycles; data is addr+0x100 except a fixed word at 0xC.
    assign imem_ack   = imem_req && (wcnt >= lat);
    assign imem_rdata = (imem_addr == 32'hC) ? 32'h00A0_0093 : imem_addr + 32'h100;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc   = p;
        e.inst = i;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every instruction IF/ID accepts must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!valid) begin
                chk("bubble_inst", inst, 32'd0);
            end else if (!stall) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_pc", pc, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", pc, e.pc);
                    chk("sb_inst", inst, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; lat = 0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);
        step();

        // Zero-latency streaming from reset.
        rst_n = 1'b1;
        push(32'h0, 32'h100);
        push(32'h4, 32'h104);
        step();
        step();

        // Two-cycle memory latency at 0x8.
        lat = 2;
        push(32'h8, 32'h108);
        @(negedge clk);
        chk("wait1_addr", imem_addr, 32'h8);
        chk("wait1_valid", {31'd0, valid}, 32'd0);
        step();
        @(negedge clk);
        chk("wait2_addr", imem_addr, 32'h8);
        chk("wait2_valid", {31'd0, valid}, 32'd0);
        step();
        @(negedge clk);
        chk("wait3_addr", imem_addr, 32'h8);
        chk("wait3_valid", {31'd0, valid}, 32'd1);
`ifdef IFU_PERF_CNT_EN
        chk("perf_cnt_2", wait_cnt, 32'd2);
`endif
        step();

        // Stall on the ack at 0xC, held for three cycles.
        lat = 0;
        stall = 1'b1;
        push(32'hC, 32'h00A0_0093);
        @(negedge clk);
        chk("stall_ack_inst", inst, 32'h00A0_0093);
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_inst", inst, 32'h00A0_0093);
            chk("hold_pc", pc, 32'hC);
        end
        step();
        stall = 1'b0;
        push(32'h10, 32'h110);
        step();
        @(negedge clk);
        chk("after_hold_addr", imem_addr, 32'h10);
        step();

        // Redirect to 0x100 while 0x14 is outstanding.
        lat = 2;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h14);
        chk("redir_valid", {31'd0, valid}, 32'd0);
        step();
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("kill_addr", imem_addr, 32'h14);
            chk("kill_valid", {31'd0, valid}, 32'd0);
            step();
        end
        lat = 0;
        stall = 1'b1;
        @(negedge clk);
        chk("kill_next_addr", imem_addr, 32'h100);
        step();

        // Redirect with stall while holding: held word at 0x100 is dropped.
        redirect = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        chk("hold_redir_valid", {31'd0, valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        stall = 1'b0;
        push(32'h200, 32'h300);
        push(32'h204, 32'h304);
        @(negedge clk);
        chk("hold_redir_addr", imem_addr, 32'h200);
        step();
        step();

        // Redirect with a same-cycle ack, then PC wrap-around.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 32'h0000_00FC);
        push(32'h0, 32'h100);
        @(negedge clk);
        chk("ack_redir_valid", {31'd0, valid}, 32'd0);
        step();
        redirect = 1'b0;
        step();
        step();

        // Reset in the middle of an unanswered request at 0x4.
        lat = 3;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        step();
`ifdef IFU_PERF_CNT_EN
        chk("perf_cnt_rst", wait_cnt, 32'd0);
`endif
        lat = 0;
        rst_n = 1'b1;
        push(32'h0, 32'h100);
        @(negedge clk);
        chk("post_rst_pc", pc, 32'd0);
        chk("post_rst_addr", imem_addr, 32'd0);
        step();
        rst_n = 1'b0;
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
